stepper_move_profiler: RTL and testbench

Upstream stage of the stepper phase sequencer. Accepts a move command (step count and direction) over a valid/ready handshake. Emits one-cycle step_tick pulses on a symmetric trapezoidal profile: accelerate from START_DIV to MIN_DIV clock cycles per step, cruise, then decelerate. step_tick and dir_out drive the sequencer's step-enable and direction inputs, replacing its fixed divided clock.

---
 rtl/stepper_move_profiler.sv | 215 +++++++++++++++++++++
 tb/tb_stepper_move_profiler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_profiler.sv
// stepper_move_profiler
//   Trapezoidal step-rate profiler feeding the stepper phase sequencer.
//   A move command (step count and direction) is accepted over valid/ready.
//   One-cycle step_tick pulses are then emitted. The spacing starts at
//   START_DIV clocks, shrinks by ACCEL_DEC per step down to MIN_DIV, holds
//   there while cruising, and ramps back up symmetrically. The move ends
//   with a one-cycle done pulse.
//
//   Optional build macro: STEP_POSITION_EN adds a signed step position
//   accumulator output.
//
// Ports:
//   clk_in      in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   cmd_valid   in   move command present
//   cmd_ready   out  high when idle; accept on cmd_valid && cmd_ready
//   cmd_steps   in   [CNT_W] number of steps to move
//   cmd_dir     in   direction for the move
//   abort       in   stop current move immediately
//   step_tick   out  one-cycle pulse per step
//   dir_out     out  direction latched at acceptance
//   busy        out  move in progress (including the done cycle)
//   done        out  one-cycle pulse at end of move
//   aborted     out  qualifies done: move ended by abort
//   steps_left  out  [CNT_W] remaining steps
//   position    out  [CNT_W+1] signed step position (STEP_POSITION_EN only)
//
// States:
//   state     | meaning
//   ST_IDLE   | waiting for a command, cmd_ready=1
//   ST_ACCEL  | ramping period down from START_DIV toward MIN_DIV
//   ST_CRUISE | period held at MIN_DIV
//   ST_DECEL  | ramping period back up toward START_DIV
//   ST_DONE   | one-cycle done pulse, then back to idle

module stepper_move_profiler #(
    parameter int CNT_W     = 16,
    parameter int PER_W     = 32,
    parameter int START_DIV = 500000,
    parameter int MIN_DIV   = 250000,
    parameter int ACCEL_DEC = 25000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             step_tick,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
`ifdef STEP_POSITION_EN
    ,
    output logic signed [CNT_W:0] position
`endif
);

    localparam logic [PER_W-1:0] START_P = PER_W'(START_DIV);
    localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_DIV);
    localparam logic [PER_W-1:0] DEC_P   = PER_W'(ACCEL_DEC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_DONE
    } state_t;

    state_t           state_q, state_nxt;
    logic [PER_W-1:0] period_q, period_nxt;
    logic [PER_W-1:0] counter_q, counter_nxt;
    logic [CNT_W-1:0] ramp_q, ramp_nxt;
    logic [CNT_W-1:0] steps_nxt;
    logic             dir_nxt;
    logic             aborted_nxt;

    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] ramp_inc;
    logic [PER_W-1:0] per_dec;
    logic [PER_W-1:0] per_inc;
    logic [PER_W-1:0] cruise_exit;

    // Saturating period arithmetic. The differences are taken against the
    // bounds first, so nothing can wrap even with PER_W near the bounds.
    always_comb begin
        rem      = steps_left - CNT_W'(1);
        ramp_inc = ramp_q + CNT_W'(1);
        per_dec  = ((period_q - MIN_P) > DEC_P) ? (period_q - DEC_P) : MIN_P;
        per_inc  = ((START_P - period_q) > DEC_P) ? (period_q + DEC_P) : START_P;
        cruise_exit = ((START_P - MIN_P) > DEC_P) ? (MIN_P + DEC_P) : START_P;
    end

    always_comb begin
        state_nxt   = state_q;
        period_nxt  = period_q;
        counter_nxt = counter_q;
        ramp_nxt    = ramp_q;
        steps_nxt   = steps_left;
        dir_nxt     = dir_out;
        aborted_nxt = aborted;
        step_tick   = 1'b0;
        cmd_ready   = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_nxt     = cmd_dir;
                    steps_nxt   = cmd_steps;
                    period_nxt  = START_P;
                    ramp_nxt    = '0;
                    counter_nxt = '0;
                    aborted_nxt = 1'b0;
                    state_nxt   = (cmd_steps == '0) ? ST_DONE : ST_ACCEL;
                end
            end

            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                if (abort) begin
                    // Abort beats a tick that would land in the same cycle.
                    aborted_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end else if (counter_q == (period_q - PER_W'(1))) begin
                    step_tick   = 1'b1;
                    counter_nxt = '0;
                    steps_nxt   = rem;
                    if (rem == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        case (state_q)
                            ST_ACCEL: begin
                                ramp_nxt = ramp_inc;
                                // Enough steps left only to ramp back down:
                                // turn around before reaching cruise speed.
                                if (rem == ramp_inc) begin
                                    state_nxt = ST_DECEL;
                                end else if (rem < ramp_inc) begin
                                    state_nxt  = ST_DECEL;
                                    period_nxt = per_inc;
                                end else begin
                                    period_nxt = per_dec;
                                    if (per_dec == MIN_P) state_nxt = ST_CRUISE;
                                end
                            end
                            ST_CRUISE: begin
                                if (rem == ramp_q) begin
                                    state_nxt  = ST_DECEL;
                                    period_nxt = cruise_exit;
                                end
                            end
                            default: begin
                                period_nxt = per_inc;
                            end
                        endcase
                    end
                end else begin
                    counter_nxt = counter_q + PER_W'(1);
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            period_q   <= START_P;
            counter_q  <= '0;
            ramp_q     <= '0;
            steps_left <= '0;
            dir_out    <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            period_q   <= period_nxt;
            counter_q  <= counter_nxt;
            ramp_q     <= ramp_nxt;
            steps_left <= steps_nxt;
            dir_out    <= dir_nxt;
            aborted    <= aborted_nxt;
        end
    end

`ifdef STEP_POSITION_EN
    // Free-running signed position; wraps, never cleared by commands.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            position <= '0;
        end else if (step_tick) begin
            position <= dir_out ? (position + (CNT_W+1)'(1))
                                : (position - (CNT_W+1)'(1));
        end
    end
`endif

endmodule

// File: tb/tb_stepper_move_profiler.sv
// Scoreboard bench for stepper_move_profiler with START_DIV=10, MIN_DIV=4,
// ACCEL_DEC=2. Stimulus drives inputs 1 time unit after the rising edge and
// pushes hand-computed tick/done events. A monitor samples on the falling
// edge, pops the events and compares them.

module tb_stepper_move_profiler;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic        abort;
    logic        step_tick;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] steps_left;
`ifdef STEP_POSITION_EN
    logic signed [16:0] position;
`endif

    stepper_move_profiler #(
        .CNT_W(16), .PER_W(32), .START_DIV(10), .MIN_DIV(4), .ACCEL_DEC(2)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .abort      (abort),
        .step_tick  (step_tick),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left)
`ifdef STEP_POSITION_EN
        ,
        .position   (position)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit is_done;
        int cyc;
        bit ab;
        int steps;
        bit dir;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_total = 0;
    int  n_pass = 0;
    bit  mon_en = 1'b0;
    bit  ready_chk = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every tick or done presented by the DUT is matched against
    // the next expected event.
    always @(negedge clk_in) begin
        ev_t e;
        if (mon_en) begin
            if (ready_chk) begin
                chk("ready_after_done", cmd_ready, 1);
                chk("busy_after_done", busy, 0);
                ready_chk = 1'b0;
            end
            if (step_tick === 1'b1 || done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {step_tick, done}, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", done, e.is_done);
                    chk("event_cycle", cyc, e.cyc);
                    if (e.is_done) begin
                        chk("done_aborted", aborted, e.ab);
                        chk("done_steps_left", steps_left, e.steps);
                        chk("done_dir_out", dir_out, e.dir);
                        chk("ready_in_done", cmd_ready, 0);
                        ready_chk = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 300; k++) begin
            if (cmd_ready === 1'b1) break;
            tick_edge();
        end
        if (k == 300) chk("wait_ready_timeout", 1, 0);
    endtask

    // Issue one command; pushes ticks at the cumulative intervals and,
    // optionally, the normal done event. Returns the acceptance cycle.
    task automatic issue(input int steps, input bit d, input int iv[$],
                         input bit push_done, input bit hold, output int base);
        int t;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_steps = 16'(steps);
        cmd_dir   = d;
        base = cyc;
        t = base;
        foreach (iv[i]) begin
            t += iv[i];
            q.push_back('{0, t, 0, 0, d});
        end
        if (push_done) q.push_back('{1, t + 1, 0, 0, d});
        tick_edge();
        if (hold) begin
            // Keep a different command on the bus while busy.
            cmd_steps = 16'd3;
            cmd_dir   = ~d;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            if (done === 1'b1) cmd_valid = 1'b0;
            if (cmd_ready === 1'b1 && q.size() == 0) break;
            tick_edge();
        end
        if (k == 300) chk("wait_idle_timeout", 1, 0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int iv[$];
        int base;

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        cmd_dir = 1'b0;
        abort = 1'b0;
        repeat (3) tick_edge();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step_tick", step_tick, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_dir_out", dir_out, 0);
        chk("rst_steps_left", steps_left, 0);
        reset = 1'b1;
        mon_en = 1'b1;
        tick_edge();

        // 6 steps: 10,8,6,6,8,10
        iv = '{10, 8, 6, 6, 8, 10};
        issue(6, 1'b1, iv, 1'b1, 1'b0, base);
        wait_idle();

        // 5 steps: 10,8,6,8,10
        iv = '{10, 8, 6, 8, 10};
        issue(5, 1'b0, iv, 1'b1, 1'b0, base);
        wait_idle();
`ifdef STEP_POSITION_EN
        chk("position_after_6_minus_5", 32'(position), 32'(1));
`endif

        // 1 step with cmd_valid held while busy
        iv = '{10};
        issue(1, 1'b1, iv, 1'b1, 1'b1, base);
        wait_idle();
        repeat (3) tick_edge();
        chk("held_valid_not_accepted", busy, 0);

        // 0 steps: done next cycle, no tick; valid held while busy
        iv = '{};
        issue(0, 1'b0, iv, 1'b1, 1'b1, base);
        wait_idle();
        repeat (3) tick_edge();
        chk("zero_held_not_accepted", busy, 0);

        // 20 steps: 10,8,6, 14x4, 6,8,10 -> last tick at +104
        iv = '{10, 8, 6};
        repeat (14) iv.push_back(4);
        iv.push_back(6); iv.push_back(8); iv.push_back(10);
        issue(20, 1'b1, iv, 1'b1, 1'b0, base);
        wait_idle();
        chk("long_move_total", q.size(), 0);

        // Abort in the cycle of the 4th tick (base+28)
        iv = '{10, 8, 6};
        issue(20, 1'b0, iv, 1'b0, 1'b0, base);
        q.push_back('{1, base + 29, 1, 17, 0});
        while (cyc < base + 28) tick_edge();
        abort = 1'b1;
        tick_edge();
        abort = 1'b0;
        wait_idle();
        repeat (20) tick_edge();
        chk("abort_aborted_held", aborted, 1);
        chk("abort_steps_held", steps_left, 17);

        // Reset while cruising
        iv = '{10, 8, 6};
        repeat (14) iv.push_back(4);
        iv.push_back(6); iv.push_back(8); iv.push_back(10);
        issue(20, 1'b1, iv, 1'b1, 1'b0, base);
        while (cyc < base + 37) tick_edge();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        @(posedge clk_in);
        q.delete();
        #1;
        reset = 1'b1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_step_tick", step_tick, 0);
        chk("midrst_dir_out", dir_out, 0);
        chk("midrst_steps_left", steps_left, 0);
        chk("midrst_aborted", aborted, 0);
        repeat (20) tick_edge();

        // Recovery after reset
        iv = '{10};
        issue(1, 1'b0, iv, 1'b1, 1'b0, base);
        wait_idle();
        repeat (3) tick_edge();

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
